// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_arbiter : two-port round-robin arbiter for a single-port dmem, with  |
// |                bus lock, starvation cap and alignment/range checking.     |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
   parameter int N        = 32,
   parameter int R        = 6,
   parameter int MAX_LOCK = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         req1,
   input  logic         we0,
   input  logic         we1,
   input  logic         lock0,
   input  logic         lock1,
   input  logic [N-1:0] addr0,
   input  logic [N-1:0] addr1,
   input  logic [N-1:0] wdata0,
   input  logic [N-1:0] wdata1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic         err0,
   output logic         err1,
   output logic [N-1:0] rdata0,
   output logic [N-1:0] rdata1,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata
);

   localparam int              CNT_W     = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
   localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(MAX_LOCK - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               last_q;
   logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic               done0_q, done1_q, err0_q, err1_q;
   logic [N-1:0]       rdata0_q, rdata1_q;

   logic               w_gnt0, w_gnt1, w_acc0, w_acc1, w_legal0, w_legal1;

   function automatic logic f_legal(input logic [N-1:0] a);
      return (a[1:0] == 2'b00) && (a[N-1:R+2] == '0);
   endfunction

   // last_q = 1 means port 1 was served last, so port 0 wins a tie.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      case (state_q)
         ST_IDLE: begin
            w_gnt0 = req0 & (~req1 | last_q);
            w_gnt1 = req1 & (~req0 | ~last_q);
         end
         ST_OWN0: w_gnt0 = req0;
         ST_OWN1: w_gnt1 = req1;
         default: ;
      endcase
   end

   assign w_acc0   = req0 & w_gnt0;
   assign w_acc1   = req1 & w_gnt1;
   assign w_legal0 = f_legal(addr0);
   assign w_legal1 = f_legal(addr1);

   // The counter saturates so a late-arriving waiter still hits the cap.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         ST_IDLE: begin
            lock_cnt_d = '0;
            if (w_acc0 && lock0)      state_d = ST_OWN0;
            else if (w_acc1 && lock1) state_d = ST_OWN1;
         end
         ST_OWN0: begin
            if (!lock0) begin
               state_d    = ST_IDLE;
               lock_cnt_d = '0;
            end else if (w_acc0) begin
               if (lock_cnt_q == c_CNT_MAX && req1) begin
                  state_d    = ST_IDLE;
                  lock_cnt_d = '0;
               end else if (lock_cnt_q != c_CNT_MAX) begin
                  lock_cnt_d = lock_cnt_q + CNT_W'(1);
               end
            end
         end
         ST_OWN1: begin
            if (!lock1) begin
               state_d    = ST_IDLE;
               lock_cnt_d = '0;
            end else if (w_acc1) begin
               if (lock_cnt_q == c_CNT_MAX && req0) begin
                  state_d    = ST_IDLE;
                  lock_cnt_d = '0;
               end else if (lock_cnt_q != c_CNT_MAX) begin
                  lock_cnt_d = lock_cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;
         lock_cnt_q <= '0;
         done0_q    <= 1'b0;
         done1_q    <= 1'b0;
         err0_q     <= 1'b0;
         err1_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         if (w_acc0)      last_q <= 1'b0;
         else if (w_acc1) last_q <= 1'b1;
         done0_q    <= w_acc0;
         done1_q    <= w_acc1;
         err0_q     <= w_acc0 & ~w_legal0;
         err1_q     <= w_acc1 & ~w_legal1;
         rdata0_q   <= (w_acc0 && !we0 && w_legal0) ? mem_rdata : '0;
         rdata1_q   <= (w_acc1 && !we1 && w_legal1) ? mem_rdata : '0;
      end
   end

   assign gnt0      = w_gnt0;
   assign gnt1      = w_gnt1;
   assign done0     = done0_q;
   assign done1     = done1_q;
   assign err0      = err0_q;
   assign err1      = err1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_we    = (w_acc0 & we0 & w_legal0) | (w_acc1 & we1 & w_legal1);
   assign mem_addr  = w_acc0 ? addr0  : (w_acc1 ? addr1  : '0);
   assign mem_wdata = w_acc0 ? wdata0 : (w_acc1 ? wdata1 : '0);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_arbiter : directed and randomized bench for dmem_arbiter against  |
// |                   a rule-level arbitration and memory model.              |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

   localparam int c_N        = 32;
   localparam int c_R        = 6;
   localparam int c_MAX_LOCK = 4;
   localparam int c_WORDS    = 1 << c_R;

   logic clk = 1'b0, reset = 1'b1, mem_init = 1'b1;
   logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
   logic [c_N-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic gnt0, gnt1, done0, done1, err0, err1, mem_we;
   logic [c_N-1:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

   logic [c_N-1:0] dmem   [c_WORDS];
   logic [c_N-1:0] refmem [c_WORDS];

   int n_vec = 0, n_miss = 0;
   int m_owner, m_last, m_streak, m_acc;
   bit p_valid, p_err;
   int p_port;
   logic [c_N-1:0] p_rdata;
   bit g0_seen, g1_seen, we_seen;

   always #5 clk = ~clk;

   dmem_arbiter #(.N(c_N), .R(c_R), .MAX_LOCK(c_MAX_LOCK)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [c_N-1:0] init_word(input int i);
      return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0F0F;
   endfunction

   // Behavioural dmem: combinational read, posedge write.
   assign mem_rdata = dmem[mem_addr[c_R+1:2]];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < c_WORDS; i++) dmem[i] <= init_word(i);
      end else if (mem_we) begin
         dmem[mem_addr[c_R+1:2]] <= mem_wdata;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_port(input int k, input bit r, input bit w, input bit l,
                           input logic [31:0] a, input logic [31:0] d);
      if (k == 0) begin req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d; end
      else        begin req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d; end
   endtask

   // One clock: check the DUT against the model at negedge, advance the model.
   task automatic cycle();
      int w;
      longint unsigned a;
      bit lg, wk, lk, lo, ro;
      logic [31:0] wd;
      @(negedge clk);
      g0_seen = gnt0; g1_seen = gnt1; we_seen = mem_we;
      if (m_owner < 0) begin
         if (req0 && req1) w = 1 - m_last;
         else if (req0)    w = 0;
         else if (req1)    w = 1;
         else              w = -1;
      end else if (m_owner == 0) begin
         w = req0 ? 0 : -1;
      end else begin
         w = req1 ? 1 : -1;
      end
      a  = (w == 1) ? longint'(addr1) : longint'(addr0);
      wd = (w == 1) ? wdata1 : wdata0;
      wk = (w == 1) ? we1 : we0;
      lk = (w == 1) ? lock1 : lock0;
      lg = (a % 4 == 0) && (a < (longint'(4) << c_R));

      chk_eq("gnt0", gnt0, 32'(w == 0));
      chk_eq("gnt1", gnt1, 32'(w == 1));
      chk_eq("done0", done0, 32'(p_valid && p_port == 0));
      chk_eq("done1", done1, 32'(p_valid && p_port == 1));
      chk_eq("err0", err0, 32'(p_valid && p_port == 0 && p_err));
      chk_eq("err1", err1, 32'(p_valid && p_port == 1 && p_err));
      chk_eq("rdata0", rdata0, (p_valid && p_port == 0) ? p_rdata : 32'h0);
      chk_eq("rdata1", rdata1, (p_valid && p_port == 1) ? p_rdata : 32'h0);
      chk_eq("mem_we", mem_we, 32'(w >= 0 && wk && lg));
      chk_eq("mem_addr", mem_addr, (w >= 0) ? 32'(a) : 32'h0);
      if (w >= 0 && wk) chk_eq("mem_wdata", mem_wdata, wd);

      p_valid = (w >= 0);
      p_port  = w;
      p_err   = !lg;
      p_rdata = (w >= 0 && !wk && lg) ? refmem[int'(a / 4)] : 32'h0;
      if (w >= 0 && wk && lg) refmem[int'(a / 4)] = wd;
      if (w >= 0) m_last = w;

      if (m_owner < 0) begin
         if (w >= 0 && lk) begin m_owner = w; m_streak = 0; end
      end else begin
         lo = (m_owner == 0) ? lock0 : lock1;
         ro = (m_owner == 0) ? req1 : req0;
         if (!lo) begin
            m_owner = -1; m_streak = 0;
         end else if (w == m_owner) begin
            if (m_streak == c_MAX_LOCK - 1 && ro) begin m_owner = -1; m_streak = 0; end
            else if (m_streak < c_MAX_LOCK - 1) m_streak++;
         end
      end
      if (reset) begin
         m_owner = -1; m_last = 1; m_streak = 0; p_valid = 1'b0;
      end
      m_acc = w;
      @(posedge clk);
      #1;
   endtask

   task automatic access(input int k, input bit w, input bit l,
                         input logic [31:0] a, input logic [31:0] d);
      set_port(k, 1'b1, w, l, a, d);
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (m_acc == k) break;
      end
      chk_eq("access_accepted", 32'(m_acc), 32'(k));
      if (k == 0) req0 = 1'b0; else req1 = 1'b0;
   endtask

   task automatic reset_pulse();
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      int n1;
      for (int i = 0; i < c_WORDS; i++) refmem[i] = init_word(i);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; mem_init = 1'b0;
      m_owner = -1; m_last = 1; m_streak = 0; m_acc = -1; p_valid = 1'b0;
      p_port = -1; p_err = 1'b0; p_rdata = '0;

      // Reset state
      chk_eq("rst_done0", done0, 0);
      chk_eq("rst_rdata0", rdata0, 0);
      cycle();

      // Read after write
      access(0, 1, 0, 32'h10, 32'hDEAD_BEEF);
      chk_eq("raw_wr_done0", done0, 1);
      access(0, 0, 0, 32'h10, 32'h0);
      chk_eq("raw_rd_rdata0", rdata0, 32'hDEAD_BEEF);

      // Contention: alternate grants from a fresh reset
      reset_pulse();
      for (int i = 0; i < 6; i++) begin
         set_port(0, 1, 0, 0, 32'(4 * i), 0);
         set_port(1, 1, 0, 0, 32'(4 * i + 8), 0);
         cycle();
         chk_eq("alt_gnt0", g0_seen, 32'((i % 2) == 0));
      end
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      cycle();

      // Lock: p1 owns the bus for 3 accepts while p0 waits
      access(1, 0, 1, 32'h20, 0);
      set_port(0, 1, 0, 0, 32'h24, 0);
      for (int i = 0; i < 2; i++) begin
         set_port(1, 1, 0, 1, 32'(32'h28 + 4 * i), 0);
         cycle();
         chk_eq("lock_gnt0", g0_seen, 0);
      end
      set_port(1, 1, 0, 0, 32'h30, 0);
      cycle();
      chk_eq("lock_last_gnt0", g0_seen, 0);
      set_port(1, 0, 0, 0, 0, 0);
      cycle();
      chk_eq("lock_release_gnt0", g0_seen, 1);
      req0 = 1'b0;
      cycle();

      // Starvation cap: p1 holds lock forever, p0 waits
      access(1, 0, 1, 32'h40, 0);
      set_port(0, 1, 0, 0, 32'h44, 0);
      set_port(1, 1, 1, 1, 32'h48, 32'h1234_5678);
      n1 = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (m_acc == 0) break;
         if (g1_seen) n1++;
      end
      chk_eq("starve_p0_granted", g0_seen, 1);
      chk_eq("starve_p1_accepts", 32'(n1), 32'(c_MAX_LOCK));
      set_port(0, 1, 0, 0, 32'h4C, 0);
      cycle();
      chk_eq("starve_relock_gnt1", g1_seen, 1);
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      cycle();

      // Misaligned and out-of-range accesses
      access(0, 0, 0, 32'h13, 0);
      chk_eq("err_rd_err0", err0, 1);
      chk_eq("err_rd_rdata0", rdata0, 0);
      access(0, 1, 0, 32'h100, 32'hCAFE_F00D);
      chk_eq("err_wr_err0", err0, 1);
      chk_eq("err_wr_mem_we", we_seen, 0);
      access(0, 0, 0, 32'h0, 0);
      chk_eq("err_mem_unchanged", rdata0, init_word(0));

      // Reset on an accept edge
      set_port(0, 1, 1, 0, 32'h50, 32'h5555_AAAA);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk_eq("rstmid_done0", done0, 0);
      chk_eq("rstmid_err0", err0, 0);
      set_port(0, 1, 0, 0, 32'h50, 0);
      set_port(1, 1, 0, 0, 32'h54, 0);
      cycle();
      chk_eq("rstmid_tie_gnt0", g0_seen, 1);
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      cycle();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            bit rq;
            logic [31:0] ad;
            rq = (k == 0) ? req0 : req1;
            if (!rq || m_acc == k) begin
               ad = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, c_WORDS - 1) * 4);
               set_port(k, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 3) == 0, ad, $urandom);
            end
         end
         reset = ($urandom_range(0, 99) == 0);
         cycle();
      end
      reset = 1'b0;
      set_port(0, 0, 0, 0, 0, 0);
      set_port(1, 0, 0, 0, 0, 0);
      cycle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
